// File: rtl/pong_pkg.sv
// Pong shared definitions.
// Holds the playfield geometry, game speeds, the game-state enum, the
// colour constants and a few small helpers used by the engine and paddles.
// No ports: imported with "import pong_pkg::*;".
package pong_pkg;

  localparam int COORD_W = 10;

  // Playfield and object geometry, in pixels
  localparam logic [COORD_W-1:0] H_ACTIVE     = 10'd640;
  localparam logic [COORD_W-1:0] V_ACTIVE     = 10'd480;
  localparam logic [COORD_W-1:0] PADDLE_W     = 10'd8;
  localparam logic [COORD_W-1:0] PADDLE_H     = 10'd64;
  localparam logic [COORD_W-1:0] PADDLE_XL    = 10'd16;
  localparam logic [COORD_W-1:0] PADDLE_XR    = 10'd616;
  localparam logic [COORD_W-1:0] BALL_SIZE    = 10'd8;
  localparam logic [COORD_W-1:0] PADDLE_SPEED = 10'd4;
  localparam logic [COORD_W-1:0] PADDLE_Y_MAX = V_ACTIVE - PADDLE_H;

  // Centre positions for a fresh serve
  localparam logic [COORD_W-1:0] BALL_X0   = 10'd316;
  localparam logic [COORD_W-1:0] BALL_Y0   = 10'd236;
  localparam logic [COORD_W-1:0] PADDLE_Y0 = 10'd208;

  // Dashed centre line
  localparam logic [COORD_W-1:0] LINE_X0 = 10'd318;
  localparam logic [COORD_W-1:0] LINE_W  = 10'd4;

  // Ball velocity is kept as a signed step per frame
  localparam logic signed [COORD_W:0] BALL_SPEED_POS = 11'sd2;
  localparam logic signed [COORD_W:0] BALL_SPEED_NEG = -11'sd2;

  // SERVE_FRAMES = 60, so the last waiting frame has count 59
  localparam logic [5:0] SERVE_LAST = 6'd59;
  localparam logic [3:0] WIN_SCORE  = 4'd9;

  // Colours packed as {r,g,b}
  localparam logic [11:0] BALL_RGB   = 12'hFF0;
  localparam logic [11:0] PADDLE_RGB = 12'hFFF;
  localparam logic [11:0] LINE_RGB   = 12'h888;
  localparam logic [11:0] BLACK_RGB  = 12'h000;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  // True when v lies in [lo, lo+len); one extra bit keeps lo+len from wrapping
  function automatic logic inSpan(input logic [COORD_W-1:0] v,
                                  input logic [COORD_W-1:0] lo,
                                  input logic [COORD_W-1:0] len);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < hi);
  endfunction

  // True when [aLo, aLo+aLen) and [bLo, bLo+bLen) overlap
  function automatic logic spanOverlap(input logic [COORD_W-1:0] aLo,
                                       input logic [COORD_W-1:0] aLen,
                                       input logic [COORD_W-1:0] bLo,
                                       input logic [COORD_W-1:0] bLen);
    return ({1'b0, aLo} + {1'b0, aLen} > {1'b0, bLo}) &&
           ({1'b0, aLo} < {1'b0, bLo} + {1'b0, bLen});
  endfunction

  function automatic logic signed [COORD_W:0] toSigned(input logic [COORD_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

  // Scores stop at the winning value and never wrap
  function automatic logic [3:0] scoreInc(input logic [3:0] s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One Pong paddle: vertical position register that steps up or down once
// per frame and stays inside the playfield.
// Ports:
//   clk_i, rst_ni  pixel clock, async active-low reset
//   step_i         frame tick, the only cycle the paddle may move
//   freeze_i       hold position regardless of buttons (game over)
//   up_i, dn_i     player buttons; both or neither means hold
//   posY_o         top edge of the paddle
module pong_paddle
  import pong_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               step_i,
  input  logic               freeze_i,
  input  logic               up_i,
  input  logic               dn_i,
  output logic [COORD_W-1:0] posY_o
);

  logic [COORD_W-1:0] posY_q;
  logic [COORD_W-1:0] posY_d;

  // Next position: step by PADDLE_SPEED and clamp at the top and bottom
  // edges instead of letting the unsigned position wrap.
  always_comb begin
    posY_d = posY_q;
    if (step_i && !freeze_i) begin
      if (up_i && !dn_i) begin
        posY_d = (posY_q >= PADDLE_SPEED) ? posY_q - PADDLE_SPEED : '0;
      end else if (dn_i && !up_i) begin
        posY_d = (posY_q + PADDLE_SPEED < PADDLE_Y_MAX) ? posY_q + PADDLE_SPEED
                                                        : PADDLE_Y_MAX;
      end
    end
  end

  // Position register, starts vertically centred
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      posY_q <= PADDLE_Y0;
    end else begin
      posY_q <= posY_d;
    end
  end

  assign posY_o = posY_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game state and pixel colour stage.
// Updates paddles, ball, scores and the SERVE/PLAY/OVER sequence once per
// frame tick, and returns a registered colour for the current pixel.
// Ports:
//   clk_i, rst_ni                pixel clock, async active-low reset
//   frameTick_i                  one-cycle pulse per frame, game update cycle
//   pixValid_i, pixX_i, pixY_i   current pixel from the VGA timing generator
//   btnLUp_i .. btnRDn_i         synchronised player buttons, active-high
//   red_o, green_o, blue_o       pixel colour, one cycle after pix*
//   scoreL_o, scoreR_o           scores
//   gameOver_o                   high while the game is over
module pong_engine
  import pong_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               frameTick_i,
  input  logic               pixValid_i,
  input  logic [COORD_W-1:0] pixX_i,
  input  logic [COORD_W-1:0] pixY_i,
  input  logic               btnLUp_i,
  input  logic               btnLDn_i,
  input  logic               btnRUp_i,
  input  logic               btnRDn_i,
  output logic [3:0]         red_o,
  output logic [3:0]         green_o,
  output logic [3:0]         blue_o,
  output logic [3:0]         scoreL_o,
  output logic [3:0]         scoreR_o,
  output logic               gameOver_o
);

  state_e                    state_q, state_d;
  logic [5:0]                serveCnt_q, serveCnt_d;
  logic [3:0]                scoreL_q, scoreL_d;
  logic [3:0]                scoreR_q, scoreR_d;
  logic [COORD_W-1:0]        ballX_q, ballX_d;
  logic [COORD_W-1:0]        ballY_q, ballY_d;
  logic signed [COORD_W:0]   ballDx_q, ballDx_d;
  logic signed [COORD_W:0]   ballDy_q, ballDy_d;
  logic [11:0]               rgb_q, rgb_d;

  logic [COORD_W-1:0]        padLY, padRY;
  logic                      padFreeze;
  logic signed [COORD_W:0]   nx, ny;
  logic                      hitL, hitR, missL, missR;
  logic                      btnAny;

  assign padFreeze = (state_q == OVER);
  assign btnAny    = btnLUp_i | btnLDn_i | btnRUp_i | btnRDn_i;

  pong_paddle uPadL (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .step_i   (frameTick_i),
    .freeze_i (padFreeze),
    .up_i     (btnLUp_i),
    .dn_i     (btnLDn_i),
    .posY_o   (padLY)
  );

  pong_paddle uPadR (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .step_i   (frameTick_i),
    .freeze_i (padFreeze),
    .up_i     (btnRUp_i),
    .dn_i     (btnRDn_i),
    .posY_o   (padRY)
  );

  // Candidate ball position one step ahead; signed so that running past the
  // left or top edge shows up as a negative value rather than a wrap.
  assign nx = toSigned(ballX_q) + ballDx_q;
  assign ny = toSigned(ballY_q) + ballDy_q;

  // Paddle contact uses the candidate x but the current y for overlap
  assign hitL = ballDx_q[COORD_W]
             && (nx <= toSigned(PADDLE_XL + PADDLE_W))
             && (nx + toSigned(BALL_SIZE) > toSigned(PADDLE_XL))
             && spanOverlap(ballY_q, BALL_SIZE, padLY, PADDLE_H);
  assign hitR = !ballDx_q[COORD_W]
             && (nx + toSigned(BALL_SIZE) >= toSigned(PADDLE_XR))
             && (nx < toSigned(PADDLE_XR + PADDLE_W))
             && spanOverlap(ballY_q, BALL_SIZE, padRY, PADDLE_H);
  assign missL = (nx < 11'sd0);
  assign missR = (nx > toSigned(H_ACTIVE - BALL_SIZE));

  // State register together with the game datapath and the colour pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SERVE;
      serveCnt_q <= '0;
      scoreL_q   <= '0;
      scoreR_q   <= '0;
      ballX_q    <= BALL_X0;
      ballY_q    <= BALL_Y0;
      ballDx_q   <= BALL_SPEED_POS;
      ballDy_q   <= BALL_SPEED_POS;
      rgb_q      <= BLACK_RGB;
    end else begin
      state_q    <= state_d;
      serveCnt_q <= serveCnt_d;
      scoreL_q   <= scoreL_d;
      scoreR_q   <= scoreR_d;
      ballX_q    <= ballX_d;
      ballY_q    <= ballY_d;
      ballDx_q   <= ballDx_d;
      ballDy_q   <= ballDy_d;
      rgb_q      <= rgb_d;
    end
  end

  // Next-state logic. Nothing moves except on a frame tick. In PLAY the wall
  // bounce and paddle bounce can both apply, but a miss recentres the ball
  // and keeps the old vertical direction, overriding any wall correction.
  always_comb begin
    state_d    = state_q;
    serveCnt_d = serveCnt_q;
    scoreL_d   = scoreL_q;
    scoreR_d   = scoreR_q;
    ballX_d    = ballX_q;
    ballY_d    = ballY_q;
    ballDx_d   = ballDx_q;
    ballDy_d   = ballDy_q;
    if (frameTick_i) begin
      case (state_q)
        SERVE: begin
          ballX_d = BALL_X0;
          ballY_d = BALL_Y0;
          if (serveCnt_q == SERVE_LAST) begin
            state_d    = PLAY;
            serveCnt_d = '0;
          end else begin
            serveCnt_d = serveCnt_q + 6'd1;
          end
        end
        PLAY: begin
          ballX_d = nx[COORD_W-1:0];
          ballY_d = ny[COORD_W-1:0];
          if (ny <= 11'sd0) begin
            ballY_d  = '0;
            ballDy_d = BALL_SPEED_POS;
          end else if (ny >= toSigned(V_ACTIVE - BALL_SIZE)) begin
            ballY_d  = V_ACTIVE - BALL_SIZE;
            ballDy_d = BALL_SPEED_NEG;
          end
          if (hitL) begin
            ballX_d  = PADDLE_XL + PADDLE_W;
            ballDx_d = BALL_SPEED_POS;
          end else if (hitR) begin
            ballX_d  = PADDLE_XR - BALL_SIZE;
            ballDx_d = BALL_SPEED_NEG;
          end
          if (missL || missR) begin
            ballX_d    = BALL_X0;
            ballY_d    = BALL_Y0;
            ballDy_d   = ballDy_q;
            serveCnt_d = '0;
            if (missL) begin
              scoreR_d = scoreInc(scoreR_q);
              ballDx_d = BALL_SPEED_NEG;
              state_d  = (scoreInc(scoreR_q) == WIN_SCORE) ? OVER : SERVE;
            end else begin
              scoreL_d = scoreInc(scoreL_q);
              ballDx_d = BALL_SPEED_POS;
              state_d  = (scoreInc(scoreL_q) == WIN_SCORE) ? OVER : SERVE;
            end
          end
        end
        OVER: begin
          if (btnAny) begin
            state_d    = SERVE;
            serveCnt_d = '0;
            scoreL_d   = '0;
            scoreR_d   = '0;
            ballX_d    = BALL_X0;
            ballY_d    = BALL_Y0;
            ballDx_d   = BALL_SPEED_POS;
            ballDy_d   = BALL_SPEED_POS;
          end
        end
        default: begin
          state_d = SERVE;
        end
      endcase
    end
  end

  // Outputs. Colour is chosen from the pre-update state so a frame tick in
  // the visible area does not disturb the pixel being drawn.
  always_comb begin
    gameOver_o = (state_q == OVER);
    rgb_d      = BLACK_RGB;
    if (pixValid_i) begin
      if ((state_q != OVER) && inSpan(pixX_i, ballX_q, BALL_SIZE)
                            && inSpan(pixY_i, ballY_q, BALL_SIZE)) begin
        rgb_d = BALL_RGB;
      end else if ((inSpan(pixX_i, PADDLE_XL, PADDLE_W) && inSpan(pixY_i, padLY, PADDLE_H)) ||
                   (inSpan(pixX_i, PADDLE_XR, PADDLE_W) && inSpan(pixY_i, padRY, PADDLE_H))) begin
        rgb_d = PADDLE_RGB;
      end else if (inSpan(pixX_i, LINE_X0, LINE_W) && !pixY_i[4]) begin
        rgb_d = LINE_RGB;
      end
    end
  end

  assign red_o    = rgb_q[11:8];
  assign green_o  = rgb_q[7:4];
  assign blue_o   = rgb_q[3:0];
  assign scoreL_o = scoreL_q;
  assign scoreR_o = scoreR_q;

endmodule

// File: tb/tb_pong_engine.sv
// Testbench for pong_engine: pixel colour vectors from a table, then
// hand-worked game sequences (serve timing, wall bounce, paddle hit, miss,
// game over and restart).
module tb_pong_engine;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       frameTick;
  logic       pixValid;
  logic [9:0] pixX;
  logic [9:0] pixY;
  logic       btnLUp, btnLDn, btnRUp, btnRDn;
  logic [3:0] red, green, blue;
  logic [3:0] scoreL, scoreR;
  logic       gameOver;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        valid;
    logic [11:0] rgb;
  } pixVec_t;

  pixVec_t vecs [18];

  pong_engine dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .frameTick_i (frameTick),
    .pixValid_i  (pixValid),
    .pixX_i      (pixX),
    .pixY_i      (pixY),
    .btnLUp_i    (btnLUp),
    .btnLDn_i    (btnLDn),
    .btnRUp_i    (btnRUp),
    .btnRDn_i    (btnRDn),
    .red_o       (red),
    .green_o     (green),
    .blue_o      (blue),
    .scoreL_o    (scoreL),
    .scoreR_o    (scoreR),
    .gameOver_o  (gameOver)
  );

  // 10 ns pixel clock
  always #5 clk = ~clk;

  // Compare one value and keep the running totals
  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one pixel and wait for its registered colour
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic v);
    @(negedge clk);
    pixX     = x;
    pixY     = y;
    pixValid = v;
    @(posedge clk);
    #1;
  endtask

  // One frame tick with buttons {lUp, lDn, rUp, rDn}
  task automatic doTick(input logic [3:0] btn);
    @(negedge clk);
    frameTick = 1'b1;
    {btnLUp, btnLDn, btnRUp, btnRDn} = btn;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    {btnLUp, btnLDn, btnRUp, btnRDn} = 4'b0000;
  endtask

  task automatic runTicks(input int n, input logic [3:0] btn);
    for (int i = 0; i < n; i++) doTick(btn);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic checkBall(input string tag, input int x, input int y, input int dx, input int dy);
    checkOutput({tag, "_x"},  dut.ballX_q, x);
    checkOutput({tag, "_y"},  dut.ballY_q, y);
    checkOutput({tag, "_dx"}, $signed(dut.ballDx_q), dx);
    checkOutput({tag, "_dy"}, $signed(dut.ballDy_q), dy);
  endtask

  initial begin
    vecs[0]  = '{10'd320, 10'd0,   1'b1, 12'h888};
    vecs[1]  = '{10'd320, 10'd16,  1'b1, 12'h000};
    vecs[2]  = '{10'd320, 10'd0,   1'b0, 12'h000};
    vecs[3]  = '{10'd316, 10'd236, 1'b1, 12'hFF0};
    vecs[4]  = '{10'd323, 10'd243, 1'b1, 12'hFF0};
    vecs[5]  = '{10'd324, 10'd236, 1'b1, 12'h000};
    vecs[6]  = '{10'd315, 10'd236, 1'b1, 12'h000};
    vecs[7]  = '{10'd318, 10'd236, 1'b1, 12'hFF0};
    vecs[8]  = '{10'd16,  10'd208, 1'b1, 12'hFFF};
    vecs[9]  = '{10'd23,  10'd271, 1'b1, 12'hFFF};
    vecs[10] = '{10'd24,  10'd208, 1'b1, 12'h000};
    vecs[11] = '{10'd16,  10'd207, 1'b1, 12'h000};
    vecs[12] = '{10'd15,  10'd208, 1'b1, 12'h000};
    vecs[13] = '{10'd616, 10'd240, 1'b1, 12'hFFF};
    vecs[14] = '{10'd623, 10'd271, 1'b1, 12'hFFF};
    vecs[15] = '{10'd623, 10'd272, 1'b1, 12'h000};
    vecs[16] = '{10'd321, 10'd32,  1'b1, 12'h888};
    vecs[17] = '{10'd322, 10'd32,  1'b1, 12'h000};

    rstN      = 1'b0;
    frameTick = 1'b0;
    pixValid  = 1'b0;
    pixX      = '0;
    pixY      = '0;
    {btnLUp, btnLDn, btnRUp, btnRDn} = 4'b0000;
    #12 rstN = 1'b1;

    // Asynchronous reset in the middle of a frame while a line pixel is lit
    applyStimulus(10'd320, 10'd0, 1'b1);
    checkOutput("preResetLine", {red, green, blue}, 12'h888);
    runTicks(3, 4'b0000);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstRgb", {red, green, blue}, 0);
    checkOutput("rstScoreL", scoreL, 0);
    checkOutput("rstScoreR", scoreR, 0);
    checkOutput("rstGameOver", gameOver, 0);
    checkOutput("rstState", dut.state_q, SERVE);
    checkOutput("rstServeCnt", dut.serveCnt_q, 0);
    checkOutput("rstPadL", dut.padLY, 208);
    checkOutput("rstPadR", dut.padRY, 208);
    checkBall("rst", 316, 236, 2, 2);
    @(negedge clk);
    rstN = 1'b1;

    // Pixel colour table in the reset (SERVE) position
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].valid);
      checkOutput($sformatf("pix%0d", i), {red, green, blue}, vecs[i].rgb);
    end
    pixValid = 1'b0;

    // Serve lasts 60 ticks, the ball moves from tick 61
    runTicks(59, 4'b0000);
    checkOutput("serve59State", dut.state_q, SERVE);
    checkOutput("serve59Cnt", dut.serveCnt_q, 59);
    doTick(4'b0000);
    checkOutput("serve60State", dut.state_q, PLAY);
    checkOutput("serve60Cnt", dut.serveCnt_q, 0);
    @(negedge clk);
    frameTick = 1'b1;
    pixX      = 10'd316;
    pixY      = 10'd236;
    pixValid  = 1'b1;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    checkOutput("tickPixelPre", {red, green, blue}, 12'hFF0);
    checkBall("tick61", 318, 238, 2, 2);
    @(posedge clk);
    #1;
    checkOutput("tickPixelPost", {red, green, blue}, 12'h000);
    pixValid = 1'b0;

    // Unattended game: every point takes 219 ticks and goes to the left player
    resetDut();
    runTicks(396, 4'b0000);
    checkOutput("pt2ScoreL", scoreL, 1);
    checkBall("wallPre", 316 + 234, 2, 2, -2);
    doTick(4'b0000);
    checkBall("wallHit", 316 + 236, 0, 2, 2);
    doTick(4'b0000);
    checkOutput("wallNextY", dut.ballY_q, 2);
    runTicks(1752 - 398, 4'b0000);
    checkOutput("eightScoreL", scoreL, 8);
    checkOutput("eightScoreR", scoreR, 0);
    checkOutput("eightGameOver", gameOver, 0);
    runTicks(219, 4'b0000);
    checkOutput("nineScoreL", scoreL, 9);
    checkOutput("nineGameOver", gameOver, 1);
    checkOutput("nineState", dut.state_q, OVER);
    applyStimulus(10'd316, 10'd236, 1'b1);
    checkOutput("overBallHidden", {red, green, blue}, 12'h000);
    pixValid = 1'b0;
    doTick(4'b0000);
    checkOutput("overIdleState", dut.state_q, OVER);
    doTick(4'b0010);
    checkOutput("restartState", dut.state_q, SERVE);
    checkOutput("restartScoreL", scoreL, 0);
    checkOutput("restartGameOver", gameOver, 0);
    checkOutput("restartPadFrozen", dut.padRY, 208);
    checkBall("restart", 316, 236, 2, 2);

    // Right paddle returns the ball, left paddle at 128 returns it again
    resetDut();
    runTicks(20, 4'b1001);
    runTicks(40, 4'b0001);
    checkOutput("hitPadL", dut.padLY, 128);
    checkOutput("hitPadR", dut.padRY, 416);
    runTicks(145, 4'b0000);
    checkBall("rightPre", 606, 418, 2, -2);
    doTick(4'b0000);
    checkBall("rightHit", 608, 416, -2, -2);
    runTicks(291, 4'b0000);
    checkBall("leftPre", 26, 166, -2, 2);
    doTick(4'b0000);
    checkBall("leftHit", 24, 168, 2, 2);
    checkOutput("leftHitScoreL", scoreL, 0);
    checkOutput("leftHitScoreR", scoreR, 0);

    // Same rally with the left paddle parked at the top: left player misses
    resetDut();
    runTicks(60, 4'b1001);
    checkOutput("missPadL", dut.padLY, 0);
    runTicks(450, 4'b0000);
    checkOutput("missPreX", dut.ballX_q, 0);
    checkOutput("missPreScoreR", scoreR, 0);
    doTick(4'b0000);
    checkOutput("missScoreR", scoreR, 1);
    checkOutput("missScoreL", scoreL, 0);
    checkOutput("missState", dut.state_q, SERVE);
    checkOutput("missServeDx", $signed(dut.ballDx_q), -2);
    checkOutput("missBallX", dut.ballX_q, 316);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
